// File: rtl/onedconv_bram_loader_if.sv
// Sample-stream handshake plus banked BRAM write bus of the 1D conv loader.
// slave = loader side, master = upstream stream source / BRAM sink side.
interface onedconv_bram_loader_if #(
    parameter int DW             = 16,
    parameter int Dimension      = 16,
    parameter int ADDRESS_LENGTH = 13
);
    logic                      s_valid;
    logic [DW-1:0]             s_data;
    logic                      s_ready;
    logic [Dimension-1:0]      bram_ena;
    logic [Dimension-1:0]      bram_wea;
    logic [ADDRESS_LENGTH-1:0] bram_addr;
    logic [DW*Dimension-1:0]   bram_wdata;

    modport slave (
        input  s_valid, s_data,
        output s_ready, bram_ena, bram_wea, bram_addr, bram_wdata
    );

    modport master (
        output s_valid, s_data,
        input  s_ready, bram_ena, bram_wea, bram_addr, bram_wdata
    );
endinterface

// File: rtl/onedconv_bram_loader.sv
// Streams samples into the banked input/weight BRAMs of the 1D conv engine.
// Optional LOADER_CHECKSUM_EN adds a 32-bit running sum of accepted samples.
module onedconv_bram_loader_lane #(
    parameter int DW   = 16,
    parameter int BW   = 4,
    parameter int LANE = 0
) (
    input  logic [BW-1:0] bank,
    input  logic          wr,
    input  logic [DW-1:0] data,
    output logic          en,
    output logic [DW-1:0] wd
);
    assign en = wr && (bank == BW'(LANE));
    assign wd = data;
endmodule

module onedconv_bram_loader #(
    parameter int DW             = 16,
    parameter int Dimension      = 16,
    parameter int ADDRESS_LENGTH = 13,
    parameter int CH_WIDTH       = 10
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                mode,
    input  logic [CH_WIDTH-1:0] input_channels,
    input  logic [CH_WIDTH-1:0] temporal_length,
    input  logic [4:0]          kernel_size,
    input  logic [CH_WIDTH-1:0] filter_number,
    onedconv_bram_loader_if.slave bus,
    output logic                busy,
    output logic                done,
    output logic                cfg_err,
    output logic [31:0]         checksum
);
    localparam int BW = (Dimension > 1) ? $clog2(Dimension) : 1;
    localparam int AW = ADDRESS_LENGTH + 1;

    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

    state_t                          state_q, state_d;
    logic                            mode_q, mode_d;
    logic [CH_WIDTH-1:0]             c_len_q, c_len_d;
    logic [CH_WIDTH-1:0]             len_q, len_d;
    logic [CH_WIDTH-1:0]             f_len_q, f_len_d;
    logic [CH_WIDTH-1:0]             i_q, i_d;
    logic [CH_WIDTH-1:0]             c_q, c_d;
    logic [CH_WIDTH-1:0]             f_q, f_d;
    logic [BW-1:0]                   bank_q, bank_d;
    logic [AW-1:0]                   base_q, base_d;
    logic [Dimension-1:0]            ena_q, ena_d;
    logic [ADDRESS_LENGTH-1:0]       addr_q, addr_d;
    logic [Dimension-1:0][DW-1:0]    wdata_q, wdata_d;
    logic                            busy_q, busy_d;
    logic                            done_q, done_d;
    logic                            err_q, err_d;

    logic                            start_ok, accept, wr, ovf, last;
    logic                            cfg_zero;
    logic [AW-1:0]                   addr_full, base_inc;
    logic [Dimension-1:0]            lane_en;
    logic [Dimension-1:0][DW-1:0]    lane_wd;

    assign start_ok  = (state_q == IDLE) && start;
    assign accept    = busy_q && bus.s_valid;
    assign addr_full = base_q + AW'(i_q);
    assign ovf       = addr_full[ADDRESS_LENGTH];
    assign wr        = accept && !ovf;
    // Once a base crosses the address space it sticks there, so later
    // addresses keep flagging overflow instead of wrapping back into range.
    assign base_inc  = base_q[ADDRESS_LENGTH] ? base_q : base_q + AW'(len_q);
    assign last      = (c_q == c_len_q - CH_WIDTH'(1)) && (i_q == len_q - CH_WIDTH'(1)) &&
                       (!mode_q || (f_q == f_len_q - CH_WIDTH'(1)));
    assign cfg_zero  = (input_channels == '0) ||
                       (mode ? ((kernel_size == '0) || (filter_number == '0))
                             : (temporal_length == '0));

    for (genvar l = 0; l < Dimension; l++) begin : g_lane
        onedconv_bram_loader_lane #(.DW(DW), .BW(BW), .LANE(l)) u_lane (
            .bank (bank_q),
            .wr   (wr),
            .data (bus.s_data),
            .en   (lane_en[l]),
            .wd   (lane_wd[l])
        );
    end

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        c_len_d = c_len_q;
        len_d   = len_q;
        f_len_d = f_len_q;
        i_d     = i_q;
        c_d     = c_q;
        f_d     = f_q;
        bank_d  = bank_q;
        base_d  = base_q;
        ena_d   = '0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = err_q;
        unique case (state_q)
            IDLE: if (start) begin
                mode_d  = mode;
                c_len_d = input_channels;
                len_d   = mode ? CH_WIDTH'(kernel_size) : temporal_length;
                f_len_d = filter_number;
                i_d     = '0;
                c_d     = '0;
                f_d     = '0;
                bank_d  = '0;
                base_d  = '0;
                err_d   = cfg_zero;
                if (cfg_zero) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else begin
                    state_d = LOAD;
                    busy_d  = 1'b1;
                end
            end
            LOAD: if (accept) begin
                if (wr) begin
                    ena_d   = lane_en;
                    addr_d  = addr_full[ADDRESS_LENGTH-1:0];
                    wdata_d = lane_wd;
                end else begin
                    err_d = 1'b1;
                end
                if (i_q == len_q - CH_WIDTH'(1)) begin
                    i_d = '0;
                    // End of a filter's channels starts a fresh slot row: the
                    // next filter base is the last slot base plus one K.
                    if (c_q == c_len_q - CH_WIDTH'(1)) begin
                        c_d    = '0;
                        bank_d = '0;
                        f_d    = f_q + CH_WIDTH'(1);
                        base_d = base_inc;
                    end else begin
                        c_d = c_q + CH_WIDTH'(1);
                        if (bank_q == BW'(Dimension - 1)) begin
                            bank_d = '0;
                            base_d = base_inc;
                        end else begin
                            bank_d = bank_q + BW'(1);
                        end
                    end
                end else begin
                    i_d = i_q + CH_WIDTH'(1);
                end
                if (last) begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            mode_q  <= 1'b0;
            c_len_q <= '0;
            len_q   <= '0;
            f_len_q <= '0;
            i_q     <= '0;
            c_q     <= '0;
            f_q     <= '0;
            bank_q  <= '0;
            base_q  <= '0;
            ena_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            c_len_q <= c_len_d;
            len_q   <= len_d;
            f_len_q <= f_len_d;
            i_q     <= i_d;
            c_q     <= c_d;
            f_q     <= f_d;
            bank_q  <= bank_d;
            base_q  <= base_d;
            ena_q   <= ena_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

`ifdef LOADER_CHECKSUM_EN
    logic [31:0] sum_q, sum_d;

    always_comb begin
        sum_d = sum_q;
        if (start_ok)    sum_d = '0;
        else if (accept) sum_d = sum_q + 32'(bus.s_data);
    end

    always_ff @(posedge clk) begin
        if (rst) sum_q <= '0;
        else     sum_q <= sum_d;
    end

    assign checksum = sum_q;
`else
    assign checksum = '0;
`endif

    assign bus.s_ready    = busy_q;
    assign bus.bram_ena   = ena_q;
    assign bus.bram_wea   = ena_q;
    assign bus.bram_addr  = addr_q;
    assign bus.bram_wdata = wdata_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign cfg_err        = err_q;
endmodule

// File: tb/tb_onedconv_bram_loader.sv
// Directed bench for onedconv_bram_loader: layouts, timing, backpressure,
// config error and reset; a negedge monitor logs strobes and done pulses.
module tb_onedconv_bram_loader;
    localparam int DW  = 16;
    localparam int DIM = 16;
    localparam int AL  = 13;
    localparam int CW  = 10;
`ifdef LOADER_CHECKSUM_EN
    localparam logic [31:0] EXP_CS = 32'd120;
`else
    localparam logic [31:0] EXP_CS = 32'd0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          mode = 1'b0;
    logic [CW-1:0] input_channels = '0;
    logic [CW-1:0] temporal_length = '0;
    logic [4:0]    kernel_size = '0;
    logic [CW-1:0] filter_number = '0;
    logic          busy, done, cfg_err;
    logic [31:0]   checksum;

    onedconv_bram_loader_if #(.DW(DW), .Dimension(DIM), .ADDRESS_LENGTH(AL)) bus ();

    onedconv_bram_loader #(.DW(DW), .Dimension(DIM), .ADDRESS_LENGTH(AL), .CH_WIDTH(CW)) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .mode            (mode),
        .input_channels  (input_channels),
        .temporal_length (temporal_length),
        .kernel_size     (kernel_size),
        .filter_number   (filter_number),
        .bus             (bus),
        .busy            (busy),
        .done            (done),
        .cfg_err         (cfg_err),
        .checksum        (checksum)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [DIM-1:0]    ena;
        logic [DIM-1:0]    wea;
        logic [AL-1:0]     addr;
        logic [DW*DIM-1:0] wdata;
        int                cyc;
    } wr_t;

    wr_t           wr_q[$];
    int            acc_q[$];
    logic [DW-1:0] smp[$];
    int            done_cnt = 0;
    int            done_cyc = 0;
    logic [31:0]   cs_at_done = '0;
    int            start_cyc = 0;
    int            errors = 0;
    int            checks = 0;

    always @(negedge clk) begin : monitor
        wr_t w;
        if (bus.bram_ena !== '0 || bus.bram_wea !== '0) begin
            w.ena = bus.bram_ena; w.wea = bus.bram_wea; w.addr = bus.bram_addr;
            w.wdata = bus.bram_wdata; w.cyc = cyc;
            wr_q.push_back(w);
        end
        if (done === 1'b1) begin
            done_cnt++; done_cyc = cyc; cs_at_done = checksum;
        end
    end

    task automatic clear_log();
        wr_q.delete(); acc_q.delete(); done_cnt = 0; done_cyc = 0;
    endtask

    task automatic do_start(input bit m, input int c, input int t, input int k, input int f);
        @(posedge clk); #1;
        mode = m; input_channels = CW'(c); temporal_length = CW'(t);
        kernel_size = 5'(k); filter_number = CW'(f);
        start = 1'b1; start_cyc = cyc;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // bp selects the 1,0,0,1 valid pattern; inj is the iteration that pulses a stray start.
    task automatic feed(input int n, input bit bp, input int inj);
        int idx = 0;
        int it = 0;
        logic [3:0] pat = 4'b1001;
        while (idx < n && it < 4 * n + 20) begin
            bus.s_valid = bp ? pat[it % 4] : 1'b1;
            bus.s_data  = smp[idx];
            if (it == inj) begin start = 1'b1; mode = 1'b0; temporal_length = '0; end
            @(negedge clk);
            if (bus.s_valid && bus.s_ready) begin acc_q.push_back(cyc); idx++; end
            @(posedge clk); #1;
            start = 1'b0; it++;
        end
        bus.s_valid = 1'b0;
        checks++;
        if (idx != n) begin errors++; $display("FAIL feed_accepts got=%0d want=%0d", idx, n); end
    endtask

    task automatic build_input(input int c, input int t);
        smp.delete();
        for (int ch = 0; ch < c; ch++)
            for (int tt = 0; tt < t; tt++) smp.push_back(DW'(ch * 100 + tt));
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks += 9;
        if (bus.bram_ena !== '0)   begin errors++; $display("FAIL rst_ena got=%h want=0", bus.bram_ena); end
        if (bus.bram_wea !== '0)   begin errors++; $display("FAIL rst_wea got=%h want=0", bus.bram_wea); end
        if (bus.bram_addr !== '0)  begin errors++; $display("FAIL rst_addr got=%h want=0", bus.bram_addr); end
        if (bus.bram_wdata !== '0) begin errors++; $display("FAIL rst_wdata got=%h want=0", bus.bram_wdata); end
        if (bus.s_ready !== 1'b0)  begin errors++; $display("FAIL rst_s_ready got=%b want=0", bus.s_ready); end
        if (busy !== 1'b0)         begin errors++; $display("FAIL rst_busy got=%b want=0", busy); end
        if (done !== 1'b0)         begin errors++; $display("FAIL rst_done got=%b want=0", done); end
        if (cfg_err !== 1'b0)      begin errors++; $display("FAIL rst_cfg_err got=%b want=0", cfg_err); end
        if (checksum !== '0)       begin errors++; $display("FAIL rst_checksum got=%0d want=0", checksum); end
        @(posedge clk); #1 rst = 1'b0;
    endtask

    task automatic test_input_c1();
        wr_t lastw;
        clear_log(); build_input(1, 16);
        do_start(1'b0, 1, 16, 0, 0);
        feed(16, 1'b0, -1);
        repeat (3) @(negedge clk);
        checks++;
        if (wr_q.size() != 16) begin errors++; $display("FAIL c1_strobes got=%0d want=16", wr_q.size()); end
        for (int i = 0; i < wr_q.size(); i++) begin
            checks++;
            if (wr_q[i].ena !== 16'h0001 || wr_q[i].wea !== 16'h0001 || wr_q[i].addr !== AL'(i)) begin
                errors++;
                $display("FAIL c1_write%0d ena=%h wea=%h addr=%0d want ena=0001 addr=%0d",
                         i, wr_q[i].ena, wr_q[i].wea, wr_q[i].addr, i);
            end
        end
        lastw.wdata = 'x; lastw.cyc = -1;
        if (wr_q.size() > 0) lastw = wr_q[wr_q.size() - 1];
        checks += 5;
        if (lastw.wdata !== {16{16'h000F}}) begin errors++; $display("FAIL c1_last_wdata got=%h", lastw.wdata); end
        if (done_cnt != 1) begin errors++; $display("FAIL c1_done_count got=%0d want=1", done_cnt); end
        if (done_cyc != lastw.cyc) begin errors++; $display("FAIL c1_done_align got=%0d want=%0d", done_cyc, lastw.cyc); end
        if (done_cyc - start_cyc != 17) begin errors++; $display("FAIL c1_latency got=%0d want=17", done_cyc - start_cyc); end
        if (cs_at_done !== EXP_CS) begin errors++; $display("FAIL c1_checksum got=%0d want=%0d", cs_at_done, EXP_CS); end
    endtask

    task automatic test_input_c20();
        clear_log(); build_input(20, 8);
        do_start(1'b0, 20, 8, 0, 0);
        feed(160, 1'b0, -1);
        repeat (3) @(negedge clk);
        checks += 2;
        if (wr_q.size() != 160) begin errors++; $display("FAIL c20_strobes got=%0d want=160", wr_q.size()); end
        if (done_cnt != 1) begin errors++; $display("FAIL c20_done_count got=%0d want=1", done_cnt); end
        if (wr_q.size() == 160) begin
            for (int i = 0; i < 160; i++) begin
                logic [DIM-1:0] e;
                logic [DW-1:0] d;
                int ch, t;
                ch = i / 8; t = i % 8; e = '0; e[ch % DIM] = 1'b1; d = DW'(ch * 100 + t);
                checks++;
                if (wr_q[i].ena !== e || wr_q[i].wea !== e || wr_q[i].addr !== AL'((ch / DIM) * 8 + t) ||
                    wr_q[i].wdata !== {DIM{d}}) begin
                    errors++;
                    $display("FAIL c20_write ch=%0d t=%0d ena=%h addr=%0d want ena=%h addr=%0d",
                             ch, t, wr_q[i].ena, wr_q[i].addr, e, (ch / DIM) * 8 + t);
                end
            end
            checks += 2;
            if (wr_q[139].ena !== 16'h0002 || wr_q[139].addr !== 13'd11 || wr_q[139].wdata[15:0] !== 16'd1703) begin
                errors++;
                $display("FAIL c20_ch17t3 ena=%h addr=%0d data=%0d want 0002/11/1703",
                         wr_q[139].ena, wr_q[139].addr, wr_q[139].wdata[15:0]);
            end
            if (wr_q[127].ena !== 16'h8000 || wr_q[127].addr !== 13'd7) begin
                errors++;
                $display("FAIL c20_ch15t7 ena=%h addr=%0d want 8000/7", wr_q[127].ena, wr_q[127].addr);
            end
        end
    endtask

    task automatic test_weight();
        int tc[2][3] = '{'{4, 3, 2}, '{18, 2, 2}};
        for (int n = 0; n < 2; n++) begin
            int c, k, f, s, tot, maxa;
            c = tc[n][0]; k = tc[n][1]; f = tc[n][2];
            s = (c + DIM - 1) / DIM; tot = c * k * f; maxa = 0;
            clear_log(); smp.delete();
            for (int ff = 0; ff < f; ff++)
                for (int cc = 0; cc < c; cc++)
                    for (int kk = 0; kk < k; kk++) smp.push_back(DW'(ff * 100 + cc * 10 + kk));
            do_start(1'b1, c, 0, k, f);
            feed(tot, 1'b0, -1);
            repeat (3) @(negedge clk);
            checks += 2;
            if (wr_q.size() != tot) begin errors++; $display("FAIL w%0d_strobes got=%0d want=%0d", n, wr_q.size(), tot); end
            if (done_cnt != 1) begin errors++; $display("FAIL w%0d_done_count got=%0d want=1", n, done_cnt); end
            if (wr_q.size() == tot) begin
                for (int i = 0; i < tot; i++) begin
                    logic [DIM-1:0] e;
                    int ff, cc, kk, a;
                    kk = i % k; cc = (i / k) % c; ff = i / (k * c);
                    a = ((ff * s) + cc / DIM) * k + kk;
                    e = '0; e[cc % DIM] = 1'b1;
                    if (int'(wr_q[i].addr) > maxa) maxa = int'(wr_q[i].addr);
                    checks++;
                    if (wr_q[i].ena !== e || wr_q[i].wea !== e || wr_q[i].addr !== AL'(a) ||
                        wr_q[i].wdata[DW-1:0] !== smp[i]) begin
                        errors++;
                        $display("FAIL w%0d_write f=%0d c=%0d k=%0d ena=%h addr=%0d want ena=%h addr=%0d",
                                 n, ff, cc, kk, wr_q[i].ena, wr_q[i].addr, e, a);
                    end
                end
                checks++;
                if (maxa != (f * s) * k - 1) begin errors++; $display("FAIL w%0d_max_addr got=%0d want=%0d", n, maxa, f * s * k - 1); end
                if (n == 0) begin
                    checks++;
                    if (wr_q[19].ena !== 16'h0004 || wr_q[19].addr !== 13'd4) begin
                        errors++;
                        $display("FAIL w0_f1c2k1 ena=%h addr=%0d want 0004/4", wr_q[19].ena, wr_q[19].addr);
                    end
                end
            end
        end
    endtask

    task automatic test_backpressure();
        clear_log(); build_input(1, 4);
        do_start(1'b0, 1, 4, 0, 0);
        feed(4, 1'b1, 1);
        repeat (3) @(negedge clk);
        checks += 3;
        if (wr_q.size() != 4) begin errors++; $display("FAIL bp_strobes got=%0d want=4", wr_q.size()); end
        if (done_cnt != 1) begin errors++; $display("FAIL bp_done_count got=%0d want=1", done_cnt); end
        if (cfg_err !== 1'b0) begin errors++; $display("FAIL bp_stray_start cfg_err=%b want=0", cfg_err); end
        if (wr_q.size() == 4 && acc_q.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (wr_q[i].addr !== AL'(i) || wr_q[i].cyc != acc_q[i] + 1) begin
                    errors++;
                    $display("FAIL bp_write%0d addr=%0d cyc=%0d want addr=%0d cyc=%0d",
                             i, wr_q[i].addr, wr_q[i].cyc, i, acc_q[i] + 1);
                end
            end
        end
    endtask

    task automatic test_cfg_err();
        clear_log();
        do_start(1'b0, 3, 0, 0, 0);
        @(negedge clk); @(posedge clk); @(negedge clk);
        checks += 4;
        if (done_cnt != 1 || done_cyc > start_cyc + 2) begin
            errors++; $display("FAIL cfg_done count=%0d cyc=%0d want 1 by %0d", done_cnt, done_cyc, start_cyc + 2);
        end
        if (cfg_err !== 1'b1) begin errors++; $display("FAIL cfg_err_set got=%b want=1", cfg_err); end
        if (wr_q.size() != 0) begin errors++; $display("FAIL cfg_strobes got=%0d want=0", wr_q.size()); end
        if (busy !== 1'b0) begin errors++; $display("FAIL cfg_busy got=%b want=0", busy); end
        clear_log(); build_input(1, 2);
        do_start(1'b0, 1, 2, 0, 0);
        @(negedge clk);
        checks += 2;
        if (cfg_err !== 1'b0) begin errors++; $display("FAIL cfg_err_clear got=%b want=0", cfg_err); end
        if (busy !== 1'b1) begin errors++; $display("FAIL cfg_restart_busy got=%b want=1", busy); end
        @(posedge clk); #1;
        feed(2, 1'b0, -1);
        repeat (3) @(negedge clk);
        checks++;
        if (done_cnt != 1 || wr_q.size() != 2) begin
            errors++; $display("FAIL cfg_restart_load done=%0d strobes=%0d want 1/2", done_cnt, wr_q.size());
        end
    endtask

    task automatic test_reset_mid();
        clear_log(); build_input(1, 16);
        do_start(1'b0, 1, 16, 0, 0);
        feed(5, 1'b0, -1);
        rst = 1'b1;
        @(posedge clk); @(negedge clk);
        checks += 7;
        if (bus.bram_ena !== '0 || bus.bram_wea !== '0) begin errors++; $display("FAIL rm_ena got=%h want=0", bus.bram_ena); end
        if (bus.bram_addr !== '0) begin errors++; $display("FAIL rm_addr got=%0d want=0", bus.bram_addr); end
        if (bus.bram_wdata !== '0) begin errors++; $display("FAIL rm_wdata got=%h want=0", bus.bram_wdata); end
        if (busy !== 1'b0 || bus.s_ready !== 1'b0) begin errors++; $display("FAIL rm_busy got=%b/%b want=0", busy, bus.s_ready); end
        if (done !== 1'b0) begin errors++; $display("FAIL rm_done got=%b want=0", done); end
        if (cfg_err !== 1'b0) begin errors++; $display("FAIL rm_cfg_err got=%b want=0", cfg_err); end
        if (checksum !== '0) begin errors++; $display("FAIL rm_checksum got=%0d want=0", checksum); end
        @(posedge clk); #1 rst = 1'b0;
        repeat (20) @(negedge clk);
        checks += 2;
        if (done_cnt != 0) begin errors++; $display("FAIL rm_no_done got=%0d want=0", done_cnt); end
        if (wr_q.size() != 5) begin errors++; $display("FAIL rm_strobes got=%0d want=5", wr_q.size()); end
    endtask

    initial begin
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        test_reset();
        test_input_c1();
        test_input_c20();
        test_weight();
        test_backpressure();
        test_cfg_err();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/onedconv_bram_loader.md
Name: onedconv_bram_loader

Overview:
- Streaming loader that fills the banked input-data or weight BRAMs of the 1D convolution engine from a serial valid/ready sample stream.
- Generates per-bank one-hot enables, addresses and replicated write data in the engine's required layout, so upstream logic no longer hand-sequences BRAM writes.
- Sits between the host/DMA stream and the engine's ena/wea/addr/data write ports. One instance per BRAM group; mode is selected at start.

Parameters:
- DW, 16, sample width in bits
- Dimension, 16, number of BRAM banks (PE columns)
- ADDRESS_LENGTH, 13, BRAM address width
- CH_WIDTH, 10, width of channel/filter/length config fields

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- start  in  1  begin load; sampled only in IDLE
- mode  in  1  0 = input-data layout, 1 = weight layout; latched at start
- input_channels  in  CH_WIDTH  C
- temporal_length  in  CH_WIDTH  T (input mode)
- kernel_size  in  5  K (weight mode)
- filter_number  in  CH_WIDTH  F (weight mode)
- s_valid  in  1  sample valid
- s_data  in  DW  sample
- s_ready  out  1  loader accepts sample
- bram_ena  out  Dimension  one-hot bank enable
- bram_wea  out  Dimension  one-hot bank write enable, equal to bram_ena
- bram_addr  out  ADDRESS_LENGTH  write address
- bram_wdata  out  DW*Dimension  s_data replicated to all lanes
- busy  out  1  high in LOAD
- done  out  1  one-cycle completion pulse
- cfg_err  out  1  sticky config error, cleared by next accepted start
- checksum  out  32  see Optional Feature

Behaviour:
- Reset values: all outputs 0. FSM returns to IDLE and all counters clear. Reset mid-load aborts with no done pulse.
- FSM has three states: IDLE, LOAD, DONE.
- IDLE -> LOAD on start. Config fields and mode are latched on that start. A start seen in LOAD or DONE is ignored.
- IDLE -> DONE directly if any of these is zero: C; T (when mode=0); K or F (when mode=1). In that case cfg_err=1 and no writes occur.
- s_ready = 1 only in LOAD. A sample is accepted when s_valid && s_ready.
- Write latency is 1 cycle. In the cycle after acceptance, bram_ena/bram_wea carry the one-hot bank and bram_addr/bram_wdata are valid. In every other cycle ena/wea are 0; addr and wdata hold their last values.
- Input mode stream order: channel-major, then t = 0..T-1.
  - bank = ch mod Dimension
  - addr = (ch div Dimension)*T + t
- Weight mode stream order: f outer, c middle, k inner.
  - S = ceil(C/Dimension)
  - bank = c mod Dimension
  - addr = ((f*S) + c div Dimension)*K + k
- No multipliers. Addresses come from incremental counters: an inner index counter, a bank counter, and slot-base accumulators that add T (or K) when the bank wraps from Dimension-1 to 0. The filter base advances by S*K per filter.
- Address arithmetic uses ADDRESS_LENGTH+1 bits. If a generated address reaches 2^ADDRESS_LENGTH:
  - set cfg_err
  - suppress that write
  - continue consuming the stream, so the upstream side never deadlocks.
- The last sample is the one at final ch/t or final f/c/k. LOAD -> DONE after its acceptance; s_ready drops in the next cycle.
- DONE lasts one cycle. done=1 is aligned with the final write strobe. DONE -> IDLE.
- Samples arriving when s_ready=0 are not consumed; upstream holds them.

Optional Feature:
- Macro: LOADER_CHECKSUM_EN.
- Defined: checksum is a 32-bit wrapping sum of every accepted s_data, zero-extended. It clears on an accepted start, updates one cycle after each accept, and is final when done is high.
- Undefined: checksum is tied to 0, no adder is synthesised, and all other behaviour is identical.

Test Plan:
- Input mode, C=1, T=16, data = ch*100+t, s_valid held high:
  - 16 writes, each with ena=16'h0001 and addr 0..15
  - wdata on the last write is 16 copies of 16'h000F
  - done is coincident with the 16th strobe; total 17 cycles from start to done.
- Input mode, C=20, T=8:
  - sample ch=17, t=3 writes bank 1 (ena=16'h0002), addr 11, data 1703
  - ch=15 t=7 writes ena=16'h8000, addr 7
  - exactly 160 strobes.
- Weight mode, C=4, K=3, F=2 (S=1):
  - f=1, c=2, k=1 writes ena=16'h0004, addr 4
  - 24 strobes; max addr 5.
- Backpressure and illegal start:
  - s_valid toggles 1,0,0,1 with C=1, T=4: strobes appear only one cycle after each accept, addrs 0..3 in order.
  - A start pulse during LOAD has no effect.
- Config error and reset:
  - T=0 in input mode gives done and cfg_err=1 two cycles after start, with zero strobes.
  - Asserting rst after 5 accepts: all outputs 0 next cycle and no done.
  - A following start clears cfg_err.
- With LOADER_CHECKSUM_EN defined, C=1, T=16 pattern: checksum=120 at done. Undefined: checksum=0.
